// File: rtl/isqrt_pkg.sv
// Shared constants and state type for the isqrt responder and its users.
package isqrt_pkg;

    localparam int ISQRT_X_W   = 32;  // radicand width
    localparam int ISQRT_Y_W   = 16;  // root width
    localparam int ISQRT_R_W   = 19;  // remainder width, wide enough for any step
    localparam int ISQRT_STEPS = ISQRT_X_W / 2;  // one radix-4 step per root bit

    typedef enum logic {
        st_idle,
        st_busy
    } isqrt_state_t;

endpackage

// File: rtl/isqrt_step.sv
// One restoring radix-4 square-root step: brings in the next two radicand
// bits, trial-subtracts (q << 2) | 1 and resolves one root bit.
module isqrt_step
    import isqrt_pkg::*;
(
    input  logic [ISQRT_R_W-1:0] r_in,
    input  logic [ISQRT_Y_W-1:0] q_in,
    input  logic [1:0]           x_bits,
    output logic [ISQRT_R_W-1:0] r_out,
    output logic [ISQRT_Y_W-1:0] q_out
);

    logic [ISQRT_R_W-1:0] r_sh;
    logic [ISQRT_R_W-1:0] t;
    logic                 ge;

    // Trial subtraction; the remainder never exceeds 2q, so the top two bits
    // shifted out of r_in are always zero.
    always_comb begin
        r_sh  = (r_in << 2) | {{(ISQRT_R_W-2){1'b0}}, x_bits};
        t     = {{(ISQRT_R_W-ISQRT_Y_W-2){1'b0}}, q_in, 2'b01};
        ge    = (r_sh >= t);
        r_out = ge ? (r_sh - t) : r_sh;
        q_out = (q_in << 1) | {{(ISQRT_Y_W-1){1'b0}}, ge};
    end

endmodule

// File: rtl/isqrt_iter.sv
// Iterative floor(sqrt(x)) responder. One operation in flight; resolves
// bits_per_cycle root bits per clock, result after 16 / bits_per_cycle cycles.
module isqrt_iter
    import isqrt_pkg::*;
#(
    parameter int bits_per_cycle = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 x_vld,
    input  logic [ISQRT_X_W-1:0] x,
    output logic                 y_vld,
    output logic [ISQRT_Y_W-1:0] y
);

    localparam int LAT   = ISQRT_STEPS / bits_per_cycle;
    localparam int CNT_W = 4;

    if ((bits_per_cycle < 1) ? 1'b1 : ((ISQRT_STEPS % bits_per_cycle) != 0)) begin : g_bad_param
        $fatal(1, "isqrt_iter: bits_per_cycle must divide 16");
    end

    isqrt_state_t         state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [ISQRT_R_W-1:0] r_reg;
    logic [ISQRT_Y_W-1:0] q_reg;
    logic [ISQRT_X_W-1:0] x_reg;
    logic                 load;
    logic                 done;

    // Step chain inputs: the idle-state first step starts from the raw request.
    logic                 busy;
    logic [ISQRT_X_W-1:0] x_src;
    logic [ISQRT_X_W-1:0] x_nxt;
    logic [ISQRT_R_W-1:0] r_chain [0:bits_per_cycle];
    logic [ISQRT_Y_W-1:0] q_chain [0:bits_per_cycle];

    assign busy       = (state == st_busy);
    assign x_src      = busy ? x_reg : x;
    assign r_chain[0] = busy ? r_reg : '0;
    assign q_chain[0] = busy ? q_reg : '0;
    assign x_nxt      = x_src << (2 * bits_per_cycle);

    for (genvar i = 0; i < bits_per_cycle; i++) begin : g_step
        isqrt_step u_step (
            .r_in   (r_chain[i]),
            .q_in   (q_chain[i]),
            .x_bits (x_src[ISQRT_X_W-1-2*i -: 2]),
            .r_out  (r_chain[i+1]),
            .q_out  (q_chain[i+1])
        );
    end

    // State and step-group counter.
    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignment so every flop
        // samples pre-edge values regardless of block ordering.
        if (rst) begin
            state <= st_idle;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state, counter and datapath enables.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_nxt = state;
        cnt_nxt   = cnt;
        load      = 1'b0;
        done      = 1'b0;
        case (state)
            st_idle: begin
                if (x_vld) begin
                    load = 1'b1;
                    if (LAT == 1) begin
                        done = 1'b1;
                    end else begin
                        state_nxt = st_busy;
                        cnt_nxt   = CNT_W'(LAT - 1);
                    end
                end
            end
            st_busy: begin
                load = 1'b1;
                if (cnt == CNT_W'(1)) begin
                    done      = 1'b1;
                    state_nxt = st_idle;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: state_nxt = st_idle;
        endcase
    end

    // Datapath registers and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_reg <= '0;
            q_reg <= '0;
            x_reg <= '0;
            y     <= '0;
            y_vld <= 1'b0;
        end else begin
            y_vld <= done;
            if (load) begin
                r_reg <= r_chain[bits_per_cycle];
                q_reg <= q_chain[bits_per_cycle];
                x_reg <= x_nxt;
            end
            if (done) begin
                y <= q_chain[bits_per_cycle];
            end
        end
    end

endmodule

// File: tb/tb_isqrt_iter.sv
// Directed bench for isqrt_iter at bits_per_cycle = 1, 4 and 16.
module tb_isqrt_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] x   = '0;
    logic        vld1 = 1'b0, vld4 = 1'b0, vld16 = 1'b0;
    logic        yv1, yv4, yv16;
    logic [15:0] y1, y4, y16;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    isqrt_iter #(.bits_per_cycle(1))  u_dut1  (.clk(clk), .rst(rst), .x_vld(vld1),  .x(x), .y_vld(yv1),  .y(y1));
    isqrt_iter #(.bits_per_cycle(4))  u_dut4  (.clk(clk), .rst(rst), .x_vld(vld4),  .x(x), .y_vld(yv4),  .y(y4));
    isqrt_iter #(.bits_per_cycle(16)) u_dut16 (.clk(clk), .rst(rst), .x_vld(vld16), .x(x), .y_vld(yv16), .y(y16));

    // Bit-by-bit square search on 64-bit products, independent of the DUT recurrence.
    function automatic logic [15:0] ref_sqrt(input logic [31:0] v);
        logic [15:0] res = '0;
        logic [15:0] cand;
        longint unsigned sq;
        for (int b = 15; b >= 0; b--) begin
            cand = res | (16'd1 << b);
            sq   = longint'(cand) * longint'(cand);
            if (sq <= longint'(v)) res = cand;
        end
        return res;
    endfunction

    function automatic logic vld_of(input int sel);
        case (sel)
            1:       return yv1;
            4:       return yv4;
            default: return yv16;
        endcase
    endfunction

    function automatic logic [15:0] y_of(input int sel);
        case (sel)
            1:       return y1;
            4:       return y4;
            default: return y16;
        endcase
    endfunction

    task automatic set_vld(input int sel, input logic v);
        case (sel)
            1:       vld1  = v;
            4:       vld4  = v;
            default: vld16 = v;
        endcase
    endtask

    // Called #1 after an edge; issues one request and watches 20 cycles.
    task automatic do_op(input int sel, input logic [31:0] xv,
                         output int lat, output logic [15:0] yv, output int nres);
        x = xv;
        set_vld(sel, 1'b1);
        @(posedge clk); #1;
        set_vld(sel, 1'b0);
        lat  = -1;
        yv   = '0;
        nres = 0;
        for (int n = 1; n <= 20; n++) begin
            if (vld_of(sel)) begin
                nres++;
                if (lat < 0) begin
                    lat = n;
                    yv  = y_of(sel);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({yv1, yv4, yv16} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_vld: got %b expected 000", {yv1, yv4, yv16});
        end
        tests_run++;
        if ({y1, y4, y16} !== 48'd0) begin
            tests_failed++;
            $display("FAIL reset_y: got %h/%h/%h expected 0", y1, y4, y16);
        end
        rst = 1'b0;
    endtask

    task automatic test_corners(input int sel);
        logic [31:0] xs [9]   = '{32'd0, 32'd1, 32'd99, 32'd1000000, 32'hFFFFFFFF,
                                  32'd4294836225, 32'd4294836224, 32'd15, 32'd16};
        logic [15:0] ex [9]   = '{16'd0, 16'd1, 16'd9, 16'd1000, 16'hFFFF,
                                  16'd65535, 16'd65534, 16'd3, 16'd4};
        int lat, nres;
        logic [15:0] yv;
        for (int i = 0; i < 9; i++) begin
            do_op(sel, xs[i], lat, yv, nres);
            tests_run++;
            if (yv !== ex[i] || lat != 16 / sel || nres != 1) begin
                tests_failed++;
                $display("FAIL corner bpc=%0d x=%0d: y=%0d lat=%0d n=%0d expected y=%0d lat=%0d n=1",
                         sel, xs[i], yv, lat, nres, ex[i], 16 / sel);
            end
        end
    endtask

    task automatic test_back_to_back;
        int c1 = -1, c2 = -1, nres = 0;
        logic [15:0] r1 = '0, r2 = '0;
        x = 32'd16; vld1 = 1'b1;
        @(posedge clk); #1;
        vld1 = 1'b0;
        for (int n = 1; n <= 36; n++) begin
            if (yv1) begin
                nres++;
                if (c1 < 0) begin c1 = n; r1 = y1; end
                else if (c2 < 0) begin c2 = n; r2 = y1; end
            end
            if (n == 16) begin x = 32'd81; vld1 = 1'b1; end
            if (n == 17) vld1 = 1'b0;
            @(posedge clk); #1;
        end
        tests_run++;
        if (c1 != 16 || r1 !== 16'd4) begin
            tests_failed++;
            $display("FAIL b2b_first: cycle=%0d y=%0d expected cycle=16 y=4", c1, r1);
        end
        tests_run++;
        if (c2 != 32 || r2 !== 16'd9 || nres != 2) begin
            tests_failed++;
            $display("FAIL b2b_second: cycle=%0d y=%0d n=%0d expected cycle=32 y=9 n=2", c2, r2, nres);
        end
    endtask

    task automatic test_busy_drop;
        int c1 = -1, nres = 0;
        logic [15:0] r1 = '0;
        x = 32'd144; vld1 = 1'b1;
        @(posedge clk); #1;
        vld1 = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if (yv1) begin
                nres++;
                if (c1 < 0) begin c1 = n; r1 = y1; end
            end
            if (n == 5) begin x = 32'd4; vld1 = 1'b1; end
            if (n == 6) vld1 = 1'b0;
            @(posedge clk); #1;
        end
        tests_run++;
        if (c1 != 16 || r1 !== 16'd12 || nres != 1) begin
            tests_failed++;
            $display("FAIL busy_drop: cycle=%0d y=%0d n=%0d expected cycle=16 y=12 n=1", c1, r1, nres);
        end
    endtask

    task automatic test_reset_mid_op;
        int nres = 0, lat;
        logic [15:0] yv;
        x = 32'd625; vld1 = 1'b1;
        @(posedge clk); #1;
        vld1 = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            if (yv1) nres++;
            if (n == 7) rst = 1'b1;
            if (n == 8) rst = 1'b0;
            @(posedge clk); #1;
        end
        tests_run++;
        if (nres != 0 || y1 !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_abort: n=%0d y=%0d expected n=0 y=0", nres, y1);
        end
        do_op(1, 32'd49, lat, yv, nres);
        tests_run++;
        if (yv !== 16'd7 || lat != 16 || nres != 1) begin
            tests_failed++;
            $display("FAIL after_reset: y=%0d lat=%0d n=%0d expected y=7 lat=16 n=1", yv, lat, nres);
        end
        // Reset and request in the same cycle: the request is lost.
        nres = 0;
        x = 32'd100; vld1 = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        vld1 = 1'b0; rst = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            if (yv1) nres++;
            @(posedge clk); #1;
        end
        tests_run++;
        if (nres != 0 || y1 !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_wins: n=%0d y=%0d expected n=0 y=0", nres, y1);
        end
    endtask

    task automatic test_random(input int sel, input int count);
        int lat, nres, k;
        logic [31:0] xv;
        logic [15:0] yv, ex;
        logic [31:0] ks [8] = '{32'd1, 32'd2, 32'd3, 32'd255, 32'd256, 32'd4095, 32'd46341, 32'd65535};
        for (int i = 0; i < count + 16; i++) begin
            if (i < count) begin
                xv = $urandom;
            end else begin
                k  = ks[(i - count) / 2];
                xv = k * k - ((i - count) % 2);
            end
            ex = ref_sqrt(xv);
            do_op(sel, xv, lat, yv, nres);
            tests_run++;
            if (yv !== ex || lat != 16 / sel || nres != 1) begin
                tests_failed++;
                $display("FAIL random bpc=%0d x=%0d: y=%0d lat=%0d n=%0d expected y=%0d lat=%0d n=1",
                         sel, xv, yv, lat, nres, ex, 16 / sel);
            end
        end
    endtask

    initial begin
        test_reset();
        test_corners(1);
        test_corners(4);
        test_corners(16);
        test_back_to_back();
        test_busy_drop();
        test_reset_mid_op();
        test_random(1, 120);
        test_random(4, 120);
        test_random(16, 120);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
